// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encodings for the UART-to-bus host bridge.
// Optional feature macro used by the bridge: UART_BRIDGE_TIMEOUT_EN.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PROC  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  typedef enum logic [2:0] {
    PS_IDLE     = 3'd0,
    PS_ADDR     = 3'd1,
    PS_DATA     = 3'd2,
    PS_REQ      = 3'd3,
    PS_WAIT_RSP = 3'd4,
    PS_RESP     = 3'd5
  } parse_state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_bridge_rx.sv
// 8N1 receiver: two-flop synchroniser, falling-edge start detect, mid-bit sampling.
// Bytes with a bad stop bit are dropped; good bytes produce a one-cycle strobe.
module uart_bridge_rx
  import uart_bridge_pkg::*;
#(
  parameter int unsigned ClocksPerBaud = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_byte_valid_o
);

  localparam int unsigned CntW = cnt_width(ClocksPerBaud);
  localparam logic [CntW-1:0] CntLast = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClocksPerBaud / 2 - 1);

  logic [1:0]      rx_sync_r;
  logic            rx_prev_r;
  logic            rx_s;
  logic            fall_s;
  uart_state_e     state_r, state_n;
  logic [CntW-1:0] cnt_r, cnt_n;
  logic [2:0]      bit_r, bit_n;
  logic [7:0]      shift_r, shift_n;
  logic [7:0]      byte_r, byte_n;
  logic            valid_r, valid_n;

  assign rx_s   = rx_sync_r[1];
  assign fall_s = rx_prev_r & ~rx_s;

  // Synchronise the asynchronous line and keep the previous level for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sync_r <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      rx_sync_r <= {rx_sync_r[0], uart_rx_i};
      rx_prev_r <= rx_s;
    end
  end

  // Bit-level receive state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= {CntW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      byte_r  <= byte_n;
      valid_r <= valid_n;
    end
  end

  // Receive next-state: half-baud to the start centre, then whole bauds per bit
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    byte_n  = byte_r;
    valid_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_n = START;
          cnt_n   = {CntW{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (cnt_r == CntHalf) begin
          cnt_n = {CntW{1'b0}};
          bit_n = 3'd0;
          if (rx_s == 1'b0) begin
            state_n = PROC;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_r + CntW'(1);
        end
      end
      PROC: begin
        if (cnt_r == CntLast) begin
          cnt_n   = {CntW{1'b0}};
          shift_n = {rx_s, shift_r[7:1]};
          bit_n   = bit_r + 3'd1;
          if (bit_r == 3'd7) begin
            state_n = STOP;
          end else begin
            state_n = PROC;
          end
        end else begin
          cnt_n = cnt_r + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_r == CntLast) begin
          cnt_n   = {CntW{1'b0}};
          state_n = IDLE;
          if (rx_s == 1'b1) begin
            byte_n  = shift_r;
            valid_n = 1'b1;
          end else begin
            valid_n = 1'b0;
          end
        end else begin
          cnt_n = cnt_r + CntW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign rx_byte_o       = byte_r;
  assign rx_byte_valid_o = valid_r;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-bus host bridge: parses W/R command frames, issues one bus request, replies on TX.
// Define UART_BRIDGE_TIMEOUT_EN to abort half-received frames after TimeoutBauds bit periods.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned ClockFrequency = 1_250_000,
  parameter int unsigned BaudRate       = 19_200,
  parameter int unsigned TimeoutBauds   = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  output logic        busy_o
);

  localparam int unsigned ClocksPerBaud = ClockFrequency / BaudRate;
  localparam int unsigned CntW = cnt_width(ClocksPerBaud);
  localparam logic [CntW-1:0] CntLast = CntW'(ClocksPerBaud - 1);

  if ((ClocksPerBaud < 4) || (TimeoutBauds == 0)) begin : g_bad_cfg
    $error("uart_bus_bridge: unsupported baud or timeout configuration");
  end

  logic [7:0] rx_byte_s;
  logic       rx_valid_s;

  uart_bridge_rx #(
    .ClocksPerBaud(ClocksPerBaud)
  ) u_rx (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .uart_rx_i      (uart_rx_i),
    .rx_byte_o      (rx_byte_s),
    .rx_byte_valid_o(rx_valid_s)
  );

  parse_state_e pstate_r, pstate_n;
  logic [1:0]   idx_r, idx_n;
  logic [31:0]  addr_r, addr_n;
  logic [31:0]  wdata_r, wdata_n;
  logic [31:0]  rsp_r, rsp_n;
  logic [2:0]   rsp_left_r, rsp_left_n;
  logic         we_r, we_n;
  logic         req_r, req_n;
  logic         busy_r;
  logic         timeout_s;
  logic         tx_load_s;

  uart_state_e     tx_state_r, tx_state_n;
  logic [CntW-1:0] tx_cnt_r;
  logic            tx_tick_s;
  logic [7:0]      tx_shift_r, tx_shift_n;
  logic [2:0]      tx_bit_r, tx_bit_n;
  logic            tx_line_r, tx_line_n;
  logic [7:0]      tx_hold_r, tx_hold_n;
  logic            tx_full_r, tx_full_n;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int unsigned ToLimit = TimeoutBauds * ClocksPerBaud;
  localparam int unsigned ToW     = $clog2(ToLimit + 1);
  logic [ToW-1:0] to_cnt_r;

  // Inter-byte timer, running only while a frame is being collected
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_r <= {ToW{1'b0}};
    end else if (rx_valid_s || !((pstate_r == PS_ADDR) || (pstate_r == PS_DATA))) begin
      to_cnt_r <= {ToW{1'b0}};
    end else if (to_cnt_r != ToW'(ToLimit)) begin
      to_cnt_r <= to_cnt_r + ToW'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  assign timeout_s = (to_cnt_r == ToW'(ToLimit));
`else
  assign timeout_s = 1'b0;
`endif

  // Parser state and bus-side registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pstate_r   <= PS_IDLE;
      idx_r      <= 2'd0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      rsp_r      <= 32'h0000_0000;
      rsp_left_r <= 3'd0;
      we_r       <= 1'b0;
      req_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      pstate_r   <= pstate_n;
      idx_r      <= idx_n;
      addr_r     <= addr_n;
      wdata_r    <= wdata_n;
      rsp_r      <= rsp_n;
      rsp_left_r <= rsp_left_n;
      we_r       <= we_n;
      req_r      <= req_n;
      busy_r     <= (pstate_n != PS_IDLE);
    end
  end

  // Parser next-state; address and data shift in from the top so LE bytes land in place
  always_comb begin
    pstate_n   = pstate_r;
    idx_n      = idx_r;
    addr_n     = addr_r;
    wdata_n    = wdata_r;
    rsp_n      = rsp_r;
    rsp_left_n = rsp_left_r;
    we_n       = we_r;
    req_n      = req_r;
    tx_load_s  = 1'b0;
    case (pstate_r)
      PS_IDLE: begin
        if (rx_valid_s) begin
          idx_n = 2'd0;
          if (rx_byte_s == OP_WRITE) begin
            we_n     = 1'b1;
            pstate_n = PS_ADDR;
          end else if (rx_byte_s == OP_READ) begin
            we_n     = 1'b0;
            pstate_n = PS_ADDR;
          end else begin
            rsp_n      = {24'h00_0000, RSP_ERR};
            rsp_left_n = 3'd1;
            pstate_n   = PS_RESP;
          end
        end else begin
          pstate_n = PS_IDLE;
        end
      end
      PS_ADDR: begin
        if (rx_valid_s) begin
          addr_n = {rx_byte_s, addr_r[31:8]};
          idx_n  = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            pstate_n = we_r ? PS_DATA : PS_REQ;
            req_n    = ~we_r;
          end else begin
            pstate_n = PS_ADDR;
          end
        end else if (timeout_s) begin
          rsp_n      = {24'h00_0000, RSP_ERR};
          rsp_left_n = 3'd1;
          pstate_n   = PS_RESP;
        end else begin
          pstate_n = PS_ADDR;
        end
      end
      PS_DATA: begin
        if (rx_valid_s) begin
          wdata_n = {rx_byte_s, wdata_r[31:8]};
          idx_n   = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            pstate_n = PS_REQ;
            req_n    = 1'b1;
          end else begin
            pstate_n = PS_DATA;
          end
        end else if (timeout_s) begin
          rsp_n      = {24'h00_0000, RSP_ERR};
          rsp_left_n = 3'd1;
          pstate_n   = PS_RESP;
        end else begin
          pstate_n = PS_DATA;
        end
      end
      PS_REQ: begin
        if (host_gnt_i) begin
          req_n    = 1'b0;
          pstate_n = PS_WAIT_RSP;
        end else begin
          req_n = 1'b1;
        end
      end
      PS_WAIT_RSP: begin
        if (host_rvalid_i) begin
          pstate_n = PS_RESP;
          if (we_r) begin
            rsp_n      = {24'h00_0000, RSP_ACK};
            rsp_left_n = 3'd1;
          end else begin
            rsp_n      = host_rdata_i;
            rsp_left_n = 3'd4;
          end
        end else begin
          pstate_n = PS_WAIT_RSP;
        end
      end
      PS_RESP: begin
        if (rsp_left_r != 3'd0) begin
          if (!tx_full_r) begin
            tx_load_s  = 1'b1;
            rsp_n      = {8'h00, rsp_r[31:8]};
            rsp_left_n = rsp_left_r - 3'd1;
          end else begin
            tx_load_s = 1'b0;
          end
        end else if (!tx_full_r && (tx_state_r == IDLE)) begin
          pstate_n = PS_IDLE;
        end else begin
          pstate_n = PS_RESP;
        end
      end
      default: begin
        pstate_n = PS_IDLE;
        req_n    = 1'b0;
      end
    endcase
  end

  assign tx_tick_s = (tx_cnt_r == CntLast);

  // Free-running TX baud counter and transmitter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_cnt_r   <= {CntW{1'b0}};
      tx_state_r <= IDLE;
      tx_shift_r <= 8'h00;
      tx_bit_r   <= 3'd0;
      tx_line_r  <= 1'b1;
      tx_hold_r  <= 8'h00;
      tx_full_r  <= 1'b0;
    end else begin
      tx_cnt_r   <= tx_tick_s ? {CntW{1'b0}} : (tx_cnt_r + CntW'(1));
      tx_state_r <= tx_state_n;
      tx_shift_r <= tx_shift_n;
      tx_bit_r   <= tx_bit_n;
      tx_line_r  <= tx_line_n;
      tx_hold_r  <= tx_hold_n;
      tx_full_r  <= tx_full_n;
    end
  end

  // Transmitter next-state; the hold byte is picked up at the end of a stop bit, so no gap
  always_comb begin
    tx_state_n = tx_state_r;
    tx_shift_n = tx_shift_r;
    tx_bit_n   = tx_bit_r;
    tx_line_n  = tx_line_r;
    tx_hold_n  = tx_hold_r;
    tx_full_n  = tx_full_r;
    if (tx_load_s) begin
      tx_hold_n = rsp_r[7:0];
      tx_full_n = 1'b1;
    end else begin
      tx_full_n = tx_full_r;
    end
    case (tx_state_r)
      IDLE: begin
        if (tx_tick_s && tx_full_r) begin
          tx_shift_n = tx_hold_r;
          tx_full_n  = 1'b0;
          tx_line_n  = 1'b0;
          tx_state_n = START;
        end else begin
          tx_line_n = 1'b1;
        end
      end
      START: begin
        if (tx_tick_s) begin
          tx_line_n  = tx_shift_r[0];
          tx_shift_n = {1'b0, tx_shift_r[7:1]};
          tx_bit_n   = 3'd0;
          tx_state_n = PROC;
        end else begin
          tx_line_n = 1'b0;
        end
      end
      PROC: begin
        if (tx_tick_s) begin
          if (tx_bit_r == 3'd7) begin
            tx_line_n  = 1'b1;
            tx_state_n = STOP;
          end else begin
            tx_line_n  = tx_shift_r[0];
            tx_shift_n = {1'b0, tx_shift_r[7:1]};
            tx_bit_n   = tx_bit_r + 3'd1;
          end
        end else begin
          tx_line_n = tx_line_r;
        end
      end
      STOP: begin
        if (tx_tick_s) begin
          if (tx_full_r) begin
            tx_shift_n = tx_hold_r;
            tx_full_n  = 1'b0;
            tx_line_n  = 1'b0;
            tx_state_n = START;
          end else begin
            tx_line_n  = 1'b1;
            tx_state_n = IDLE;
          end
        end else begin
          tx_line_n = 1'b1;
        end
      end
      default: begin
        tx_line_n  = 1'b1;
        tx_state_n = IDLE;
      end
    endcase
  end

  assign uart_tx_o    = tx_line_r;
  assign host_req_o   = req_r;
  assign host_addr_o  = addr_r;
  assign host_we_o    = we_r;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = wdata_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: table of command frames plus hand-written corner cases.
module tb_uart_bus_bridge;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        uart_rx;
  logic        uart_tx;
  logic        host_req;
  logic        host_gnt;
  logic [31:0] host_addr;
  logic        host_we;
  logic [3:0]  host_be;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        busy;

  uart_bus_bridge #(
    .ClockFrequency(1_250_000),
    .BaudRate      (156_250),
    .TimeoutBauds  (64)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .uart_rx_i    (uart_rx),
    .uart_tx_o    (uart_tx),
    .host_req_o   (host_req),
    .host_gnt_i   (host_gnt),
    .host_addr_o  (host_addr),
    .host_we_o    (host_we),
    .host_be_o    (host_be),
    .host_wdata_o (host_wdata),
    .host_rvalid_i(host_rvalid),
    .host_rdata_i (host_rdata),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TX line monitor: decodes 8N1 bytes and records the cycle of each start edge
  logic [7:0] tx_q[$];
  int         tx_t[$];
  int         tx_frame_err = 0;

  initial begin : tx_mon
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2 - 1) @(negedge clk);
        if (uart_tx !== 1'b0) tx_frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) tx_frame_err++;
        tx_q.push_back(b);
        tx_t.push_back(t0);
      end
    end
  end

  // Bus responder: grant after a programmable stall, then answer with rvalid
  int          gnt_delay_v = 0;
  logic [31:0] rdata_v = 32'h0;
  logic        hold_rv = 1'b0;
  logic        release_rv = 1'b0;
  int          cap_cnt = 0;
  int          req_cyc = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_be;

  initial begin : responder
    int t;
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    host_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (host_req === 1'b1) begin
        repeat (gnt_delay_v) @(negedge clk);
        host_gnt  = 1'b1;
        cap_addr  = host_addr;
        cap_we    = host_we;
        cap_wdata = host_wdata;
        cap_be    = host_be;
        cap_cnt++;
        @(negedge clk);
        host_gnt = 1'b0;
        if (hold_rv) begin
          t = 0;
          while (!release_rv && t < 4000) begin
            @(negedge clk);
            t++;
          end
        end else begin
          repeat (2) @(negedge clk);
        end
        host_rvalid = 1'b1;
        host_rdata  = rdata_v;
        @(negedge clk);
        host_rvalid = 1'b0;
      end
    end
  end

  initial begin : req_counter
    forever begin
      @(negedge clk);
      if (host_req === 1'b1) req_cyc++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  int base_q, base_req, base_cap;

  task automatic mark();
    base_q   = tx_q.size();
    base_req = req_cyc;
    base_cap = cap_cnt;
  endtask

  task automatic check_txn(input string name, input int n_tx, input logic [31:0] exp_tx,
                           input int exp_nreq, input int exp_req_cyc, input logic [31:0] e_addr,
                           input logic e_we, input logic [31:0] e_wdata);
    int t;
    logic [31:0] exp_b;
    exp_b = exp_tx;
    t = 0;
    while ((tx_q.size() < base_q + n_tx) && (t < 4000)) begin
      @(negedge clk);
      t++;
    end
    chk({name, " tx count"}, 32'(tx_q.size() - base_q), 32'(n_tx));
    for (int i = 0; i < n_tx; i++) begin
      if (base_q + i < tx_q.size())
        chk({name, " tx byte"}, 32'(tx_q[base_q + i]), 32'(exp_b[i*8 +: 8]));
    end
    for (int i = 1; i < n_tx; i++) begin
      if (base_q + i < tx_t.size())
        chk({name, " tx spacing"}, 32'(tx_t[base_q + i] - tx_t[base_q + i - 1]), 32'(10 * CPB));
    end
    t = 0;
    while ((busy !== 1'b0) && (t < 4 * CPB)) begin
      @(negedge clk);
      t++;
    end
    chk({name, " busy after stop"}, 32'(busy), 32'd0);
    chk({name, " req count"}, 32'(cap_cnt - base_cap), 32'(exp_nreq));
    chk({name, " req cycles"}, 32'(req_cyc - base_req), 32'(exp_req_cyc));
    if (exp_nreq > 0) begin
      chk({name, " addr"}, cap_addr, e_addr);
      chk({name, " we"}, 32'(cap_we), 32'(e_we));
      chk({name, " be"}, 32'(cap_be), 32'hF);
      if (e_we) chk({name, " wdata"}, cap_wdata, e_wdata);
    end
  endtask

  typedef struct {
    string       name;
    logic [71:0] bytes;
    int          nb;
    int          gnt_dly;
    logic [31:0] rdata;
    int          exp_nreq;
    int          exp_req_cyc;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_tx;
    int          n_tx;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    mark();
    gnt_delay_v = v.gnt_dly;
    rdata_v     = v.rdata;
    for (int i = 0; i < v.nb; i++) send_byte(v.bytes[i*8 +: 8], 1'b1);
    check_txn(v.name, v.n_tx, v.exp_tx, v.exp_nreq, v.exp_req_cyc, v.exp_addr, v.exp_we,
              v.exp_wdata);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int t;
    vecs[0] = '{"write", 72'hDE_AD_BE_EF_00_00_00_10_57, 9, 0, 32'h0, 1, 1,
                32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0000_004B, 1};
    vecs[1] = '{"read stall", 72'h00_00_00_00_00_00_00_04_52, 5, 5, 32'h1234_5678, 1, 6,
                32'h0000_0004, 1'b0, 32'h0, 32'h1234_5678, 4};
    vecs[2] = '{"bad opcode", 72'h41, 1, 0, 32'h0, 0, 0,
                32'h0, 1'b0, 32'h0, 32'h0000_0045, 1};
    vecs[3] = '{"write high", 72'h80_00_00_01_FF_FF_FF_FC_57, 9, 2, 32'h0, 1, 3,
                32'hFFFF_FFFC, 1'b1, 32'h8000_0001, 32'h0000_004B, 1};
    vecs[4] = '{"read top", 72'h00_00_00_00_80_00_00_00_52, 5, 1, 32'hA5A5_5A5A, 1, 2,
                32'h8000_0000, 1'b0, 32'h0, 32'hA5A5_5A5A, 4};

    rst_i   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(uart_tx), 32'd1);
    chk("reset req", 32'(host_req), 32'd0);
    chk("reset we", 32'(host_we), 32'd0);
    chk("reset addr", host_addr, 32'h0);
    chk("reset wdata", host_wdata, 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    rst_i = 1'b0;
    repeat (4 * CPB) @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // framing error inside the address: the bad byte must be skipped entirely
    mark();
    gnt_delay_v = 0;
    rdata_v     = 32'hCAFE_F00D;
    send_byte(8'h52, 1'b1);
    send_byte(8'h77, 1'b0);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check_txn("framing", 4, 32'hCAFE_F00D, 1, 1, 32'h0000_0008, 1'b0, 32'h0);

    // reset while waiting for the response; the late rvalid must be ignored
    mark();
    hold_rv    = 1'b1;
    release_rv = 1'b0;
    rdata_v    = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) send_byte((i == 0) ? 8'h52 : ((i == 1) ? 8'h20 : 8'h00), 1'b1);
    t = 0;
    while ((cap_cnt == base_cap) && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    chk("rst grant seen", 32'(cap_cnt - base_cap), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst waiting busy", 32'(busy), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst req", 32'(host_req), 32'd0);
    chk("rst addr", host_addr, 32'h0);
    chk("rst tx", 32'(uart_tx), 32'd1);
    release_rv = 1'b1;
    t = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || host_req !== 1'b0) t++;
    end
    chk("rst late rvalid ignored", 32'(t), 32'd0);
    chk("rst no response", 32'(tx_q.size() - base_q), 32'd0);
    hold_rv    = 1'b0;
    release_rv = 1'b0;
    run_vec(vecs[0]);

    // silence in the middle of the address
    mark();
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1);
`ifdef UART_BRIDGE_TIMEOUT_EN
    check_txn("timeout", 1, 32'h0000_0045, 0, 0, 32'h0, 1'b0, 32'h0);
`else
    repeat (100 * CPB) @(negedge clk);
    chk("no timeout tx", 32'(tx_q.size() - base_q), 32'd0);
    chk("no timeout busy", 32'(busy), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("no timeout recover", 32'(busy), 32'd0);
`endif

    repeat (2 * CPB) @(negedge clk);
    chk("tx framing", 32'(tx_frame_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
